// File: rtl/fp_pkg.sv
// fp_pkg: shared single-precision types and constants for fpmul_seq.
// Optional status flags are built when FPMUL_FLAGS_EN is defined.
package fp_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } fp32_t;

    localparam logic [31:0]       FP_QNAN = 32'hFFC00000;
    localparam logic signed [9:0] FP_BIAS = 10'sd127;
    localparam logic signed [9:0] FP_EMIN = -10'sd126;
    localparam logic signed [9:0] FP_EMAX = 10'sd127;

    typedef enum logic [3:0] {
        S_IDLE,
        S_UNPACK,
        S_SPECIAL,
        S_NORM_A,
        S_NORM_B,
        S_MULT,
        S_NORM_0,
        S_NORM_1,
        S_ROUND,
        S_PACK,
        S_DONE
    } fpmul_state_e;

    // flags_o bit positions: {NV, OF, UF, NX}
    localparam int FL_NX = 0;
    localparam int FL_UF = 1;
    localparam int FL_OF = 2;
    localparam int FL_NV = 3;

endpackage

// File: rtl/fp_shift_add_step.sv
// fp_shift_add_step: one MULT cycle of the right-shifting shift-add multiplier.
// Consumes BITS_PER_CYCLE multiplier bits, LSB first.
module fp_shift_add_step
    import fp_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [47:0]               acc_i,
    input  logic [23:0]               mcand_i,
    input  logic [BITS_PER_CYCLE-1:0] mplier_i,
    output logic [47:0]               acc_o
);

    logic [47:0] acc;
    logic [24:0] sum;

    // Add the multiplicand into the top half, then shift the 49b result right.
    always_comb begin
        acc = acc_i;
        sum = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            sum = {1'b0, acc[47:24]}
                + (mplier_i[i] ? {1'b0, mcand_i} : 25'd0);
            acc = {sum, acc[23:1]};
        end
        acc_o = acc;
    end

endmodule

// File: rtl/fpmul_seq.sv
// fpmul_seq: sequential IEEE-754 single multiplier, start/done handshake.
// Define FPMUL_FLAGS_EN to add flags_o = {NV, OF, UF, NX}.
module fpmul_seq
    import fp_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] a_value_i,
    input  logic [31:0] b_value_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] z_value_o
`ifdef FPMUL_FLAGS_EN
    ,
    output logic [3:0]  flags_o
`endif
);

    localparam int         K      = 24 / BITS_PER_CYCLE;
    localparam logic [4:0] K_LAST = 5'(K - 1);

    fpmul_state_e state_q, state_d;

    fp32_t             a_q, a_d, b_q, b_d;
    logic signed [9:0] a_e_q, a_e_d, b_e_q, b_e_d;
    logic signed [9:0] z_e_q, z_e_d;
    logic [23:0]       a_m_q, a_m_d, b_m_q, b_m_d;
    logic [23:0]       z_m_q, z_m_d;
    logic              z_s_q, z_s_d;
    logic              g_q, g_d, r_q, r_d, s_q, s_d;
    logic [47:0]       prod_q, prod_d, prod_step;
    logic [4:0]        cnt_q, cnt_d;
    logic [31:0]       z_q, z_d;

    logic        a_nan, b_nan, a_inf, b_inf;
    logic        a_zero, b_zero;
    logic        inc, of;
    logic [24:0] rnd;
    logic [7:0]  exp8;

`ifdef FPMUL_FLAGS_EN
    logic       uf_q, uf_d;
    logic [3:0] flags_q, flags_d;
    logic       a_snan, b_snan;

    assign a_snan  = a_nan & ~a_q.man[22];
    assign b_snan  = b_nan & ~b_q.man[22];
    assign flags_o = flags_q;
`endif

    assign a_nan  = (a_q.exp == 8'hFF) && (a_q.man != 23'd0);
    assign b_nan  = (b_q.exp == 8'hFF) && (b_q.man != 23'd0);
    assign a_inf  = (a_q.exp == 8'hFF) && (a_q.man == 23'd0);
    assign b_inf  = (b_q.exp == 8'hFF) && (b_q.man == 23'd0);
    assign a_zero = (a_q.exp == 8'h00) && (a_q.man == 23'd0);
    assign b_zero = (b_q.exp == 8'h00) && (b_q.man == 23'd0);

    // Round-to-nearest-even increment and packing helpers.
    assign inc  = g_q & (r_q | s_q | z_m_q[0]);
    assign rnd  = {1'b0, z_m_q} + {24'd0, inc};
    assign of   = z_e_q > FP_EMAX;
    assign exp8 = z_m_q[23] ? (z_e_q[7:0] + 8'd127) : 8'd0;

    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = (state_q == S_DONE);
    assign z_value_o = z_q;

    fp_shift_add_step #(
        .BITS_PER_CYCLE(BITS_PER_CYCLE)
    ) u_step (
        .acc_i   (prod_q),
        .mcand_i (a_m_q),
        .mplier_i(b_m_q[BITS_PER_CYCLE-1:0]),
        .acc_o   (prod_step)
    );

    // Next-state and datapath updates for every FSM state.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        a_e_d   = a_e_q;
        b_e_d   = b_e_q;
        a_m_d   = a_m_q;
        b_m_d   = b_m_q;
        z_e_d   = z_e_q;
        z_m_d   = z_m_q;
        z_s_d   = z_s_q;
        g_d     = g_q;
        r_d     = r_q;
        s_d     = s_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        z_d     = z_q;
`ifdef FPMUL_FLAGS_EN
        uf_d    = uf_q;
        flags_d = flags_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    a_d     = fp32_t'(a_value_i);
                    b_d     = fp32_t'(b_value_i);
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                a_e_d   = $signed({2'b00, a_q.exp}) - FP_BIAS;
                b_e_d   = $signed({2'b00, b_q.exp}) - FP_BIAS;
                a_m_d   = {1'b0, a_q.man};
                b_m_d   = {1'b0, b_q.man};
                z_s_d   = a_q.sign ^ b_q.sign;
                state_d = S_SPECIAL;
            end
            S_SPECIAL: begin
                state_d = S_DONE;
`ifdef FPMUL_FLAGS_EN
                flags_d = 4'd0;
`endif
                if (a_nan | b_nan) begin
                    z_d = FP_QNAN;
`ifdef FPMUL_FLAGS_EN
                    flags_d[FL_NV] = a_snan | b_snan;
`endif
                end else if ((a_inf & b_zero) | (a_zero & b_inf)) begin
                    z_d = FP_QNAN;
`ifdef FPMUL_FLAGS_EN
                    flags_d[FL_NV] = 1'b1;
`endif
                end else if (a_inf | b_inf) begin
                    z_d = {z_s_q, 8'hFF, 23'd0};
                end else if (a_zero | b_zero) begin
                    z_d = {z_s_q, 31'd0};
                end else begin
                    if (a_q.exp == 8'h00) a_e_d = FP_EMIN;
                    else                  a_m_d[23] = 1'b1;
                    if (b_q.exp == 8'h00) b_e_d = FP_EMIN;
                    else                  b_m_d[23] = 1'b1;
                    state_d = S_NORM_A;
                end
            end
            S_NORM_A: begin
                if (a_m_q[23]) begin
                    state_d = S_NORM_B;
                end else begin
                    a_m_d = a_m_q << 1;
                    a_e_d = a_e_q - 10'sd1;
                end
            end
            S_NORM_B: begin
                if (b_m_q[23]) begin
                    prod_d  = '0;
                    cnt_d   = '0;
                    state_d = S_MULT;
                end else begin
                    b_m_d = b_m_q << 1;
                    b_e_d = b_e_q - 10'sd1;
                end
            end
            S_MULT: begin
                prod_d = prod_step;
                b_m_d  = b_m_q >> BITS_PER_CYCLE;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == K_LAST) begin
                    state_d = S_NORM_0;
                    if (prod_step[47]) begin
                        z_m_d = prod_step[47:24];
                        g_d   = prod_step[23];
                        r_d   = prod_step[22];
                        s_d   = |prod_step[21:0];
                        z_e_d = a_e_q + b_e_q + 10'sd1;
                    end else begin
                        z_m_d = prod_step[46:23];
                        g_d   = prod_step[22];
                        r_d   = prod_step[21];
                        s_d   = |prod_step[20:0];
                        z_e_d = a_e_q + b_e_q;
                    end
                end
            end
            S_NORM_0: begin
                if (!z_m_q[23] && (z_e_q > FP_EMIN)) begin
                    z_m_d = {z_m_q[22:0], g_q};
                    g_d   = r_q;
                    r_d   = 1'b0;
                    z_e_d = z_e_q - 10'sd1;
                end else begin
                    state_d = S_NORM_1;
                end
            end
            S_NORM_1: begin
                if (z_e_q < FP_EMIN) begin
                    z_e_d = z_e_q + 10'sd1;
                    s_d   = s_q | r_q;
                    r_d   = g_q;
                    g_d   = z_m_q[0];
                    z_m_d = z_m_q >> 1;
                end else begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                if (rnd[24]) begin
                    z_m_d = 24'h800000;
                    z_e_d = z_e_q + 10'sd1;
                end else begin
                    z_m_d = rnd[23:0];
                end
`ifdef FPMUL_FLAGS_EN
                uf_d = ~z_m_q[23] & (g_q | r_q | s_q);
`endif
                state_d = S_PACK;
            end
            S_PACK: begin
                if (of) z_d = {z_s_q, 8'hFF, 23'd0};
                else    z_d = {z_s_q, exp8, z_m_q[22:0]};
`ifdef FPMUL_FLAGS_EN
                flags_d        = 4'd0;
                flags_d[FL_OF] = of;
                flags_d[FL_UF] = uf_q;
                flags_d[FL_NX] = g_q | r_q | s_q | of;
`endif
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            a_e_q   <= '0;
            b_e_q   <= '0;
            a_m_q   <= '0;
            b_m_q   <= '0;
            z_e_q   <= '0;
            z_m_q   <= '0;
            z_s_q   <= 1'b0;
            g_q     <= 1'b0;
            r_q     <= 1'b0;
            s_q     <= 1'b0;
            prod_q  <= '0;
            cnt_q   <= '0;
            z_q     <= '0;
`ifdef FPMUL_FLAGS_EN
            uf_q    <= 1'b0;
            flags_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            a_e_q   <= a_e_d;
            b_e_q   <= b_e_d;
            a_m_q   <= a_m_d;
            b_m_q   <= b_m_d;
            z_e_q   <= z_e_d;
            z_m_q   <= z_m_d;
            z_s_q   <= z_s_d;
            g_q     <= g_d;
            r_q     <= r_d;
            s_q     <= s_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
`ifdef FPMUL_FLAGS_EN
            uf_q    <= uf_d;
            flags_q <= flags_d;
`endif
        end
    end

endmodule

// File: tb/tb_fpmul_seq.sv
// tb_fpmul_seq: directed vector table plus handshake/reset sequences
// for fpmul_seq at BITS_PER_CYCLE 1 and 8.
module tb_fpmul_seq;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] z;
        int          lat;
        logic [3:0]  fl;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        st1, st8;
    logic [31:0] a_in, b_in;
    logic        busy1, done1, busy8, done8;
    logic [31:0] z1, z8;
`ifdef FPMUL_FLAGS_EN
    logic [3:0]  fl1, fl8;
`endif

    int   n_vec = 0;
    int   n_bad = 0;
    vec_t vt[$];

    always #5 clk = ~clk;

    fpmul_seq #(.BITS_PER_CYCLE(1)) u_dut1 (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (st1),
        .a_value_i(a_in),
        .b_value_i(b_in),
        .busy_o   (busy1),
        .done_o   (done1),
        .z_value_o(z1)
`ifdef FPMUL_FLAGS_EN
        ,
        .flags_o  (fl1)
`endif
    );

    fpmul_seq #(.BITS_PER_CYCLE(8)) u_dut8 (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (st8),
        .a_value_i(a_in),
        .b_value_i(b_in),
        .busy_o   (busy8),
        .done_o   (done8),
        .z_value_o(z8)
`ifdef FPMUL_FLAGS_EN
        ,
        .flags_o  (fl8)
`endif
    );

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic add(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] z, input int lat,
                       input logic [3:0] fl);
        vec_t v;
        v.a = a; v.b = b; v.z = z; v.lat = lat; v.fl = fl;
        vt.push_back(v);
    endtask

    // Launch one operation; lat is the done cycle (-1 on timeout).
    task automatic run(input bit w, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] z,
                       output int lat, output int nbusy,
                       output logic [3:0] fl);
        int cyc;
        @(negedge clk);
        a_in = a;
        b_in = b;
        if (w) st8 = 1'b1;
        else   st1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st1   = 1'b0;
        st8   = 1'b0;
        cyc   = 1;
        nbusy = 0;
        while (1) begin
            if (w ? busy8 : busy1) nbusy++;
            if ((w ? done8 : done1) || cyc >= 400) break;
            @(negedge clk);
            cyc++;
        end
        lat = (w ? done8 : done1) ? cyc : -1;
        z   = w ? z8 : z1;
`ifdef FPMUL_FLAGS_EN
        fl  = w ? fl8 : fl1;
`else
        fl  = 4'd0;
`endif
    endtask

    function automatic logic [31:0] ref_mul(input logic [31:0] a,
                                            input logic [31:0] b);
        logic [47:0] p, q, rem, half;
        int          sh, e;
        p  = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e  = int'(a[30:23]) + int'(b[30:23]) - 127;
        sh = p[47] ? 24 : 23;
        if (p[47]) e++;
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 48'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q++;
        if (q[24]) begin
            q = q >> 1;
            e++;
        end
        return {a[31] ^ b[31], e[7:0], q[22:0]};
    endfunction

    initial begin
        logic [31:0] z, ra, rb;
        logic [3:0]  fl;
        int          lat, nb, cyc, ndone, dcyc;

        add(32'h40400000, 32'h40000000, 32'h40C00000,  33, 4'h0);
        add(32'h3F800001, 32'h3F800001, 32'h3F800002,  33, 4'h1);
        add(32'h3FC00000, 32'h3FC00000, 32'h40100000,  33, 4'h0);
        add(32'h7F800000, 32'h00000000, 32'hFFC00000,   3, 4'h8);
        add(32'h7FC00000, 32'h3F800000, 32'hFFC00000,   3, 4'h0);
        add(32'hC0000000, 32'h7F800000, 32'hFF800000,   3, 4'h0);
        add(32'h7F000000, 32'h40000000, 32'h7F800000,  33, 4'h5);
        add(32'h00800000, 32'h3F000000, 32'h00400000,  34, 4'h0);
        add(32'h00000001, 32'h3F800000, 32'h00000001,  79, 4'h0);
        add(32'h3F800001, 32'h3FC00000, 32'h3FC00002,  33, 4'h1);
        add(32'h3F800003, 32'h3FC00000, 32'h3FC00004,  33, 4'h1);
        add(32'h3F800001, 32'h3FFFFFFE, 32'h40000000,  33, 4'h1);
        add(32'h00FFFFFF, 32'h3F000000, 32'h00800000,  34, 4'h3);
        add(32'h80800000, 32'h00800000, 32'h80000000, 159, 4'h3);
        add(32'h00000001, 32'h3F000000, 32'h00000000,  80, 4'h3);
        add(32'h7F800001, 32'h3F800000, 32'hFFC00000,   3, 4'h8);
        add(32'h80000000, 32'h40400000, 32'h80000000,   3, 4'h0);
        add(32'hC0400000, 32'h40000000, 32'hC0C00000,  33, 4'h0);

        rst  = 1'b1;
        st1  = 1'b0;
        st8  = 1'b0;
        a_in = '0;
        b_in = '0;
        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, busy1}, 32'd0);
        check("reset done", {31'd0, done1}, 32'd0);
        check("reset z", z1, 32'd0);
        check("reset z bpc8", z8, 32'd0);
        rst = 1'b0;

        foreach (vt[i]) begin
            run(1'b0, vt[i].a, vt[i].b, z, lat, nb, fl);
            check($sformatf("z[%0d]", i), z, vt[i].z);
            check($sformatf("lat[%0d]", i), 32'(lat), 32'(vt[i].lat));
`ifdef FPMUL_FLAGS_EN
            check($sformatf("flags[%0d]", i), {28'd0, fl}, {28'd0, vt[i].fl});
`endif
        end

        // busy window for 3*2 and quiet cycle after done
        run(1'b0, 32'h40400000, 32'h40000000, z, lat, nb, fl);
        check("busy cycles", 32'(nb), 32'd33);
        @(negedge clk);
        check("busy after done", {31'd0, busy1}, 32'd0);
        check("done pulse width", {31'd0, done1}, 32'd0);

        // second start during busy is ignored; inputs change after latch
        @(negedge clk);
        a_in = 32'h40400000;
        b_in = 32'h40000000;
        st1  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st1   = 1'b0;
        a_in  = 32'h3F800000;
        b_in  = 32'h3F800000;
        ndone = 0;
        dcyc  = -1;
        z     = '0;
        for (cyc = 1; cyc <= 80; cyc++) begin
            if (cyc == 5) st1 = 1'b1;
            if (cyc == 6) st1 = 1'b0;
            if (done1) begin
                ndone++;
                dcyc = cyc;
                z    = z1;
            end
            @(negedge clk);
        end
        check("ignored start done count", 32'(ndone), 32'd1);
        check("ignored start done cycle", 32'(dcyc), 32'd33);
        check("ignored start result", z, 32'h40C00000);

        // reset at cycle 10 aborts the operation
        @(negedge clk);
        a_in = 32'h3FC00000;
        b_in = 32'h3FC00000;
        st1  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st1 = 1'b0;
        for (cyc = 1; cyc < 10; cyc++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", {31'd0, busy1}, 32'd0);
        check("abort z", z1, 32'd0);
        ndone = 0;
        for (cyc = 0; cyc < 50; cyc++) begin
            if (done1) ndone++;
            @(negedge clk);
        end
        check("abort no done", 32'(ndone), 32'd0);

        // BITS_PER_CYCLE = 8
        run(1'b1, 32'h40400000, 32'h40000000, z, lat, nb, fl);
        check("bpc8 3*2", z, 32'h40C00000);
        check("bpc8 lat", 32'(lat), 32'd12);
        run(1'b1, 32'h3F800001, 32'h3FFFFFFE, z, lat, nb, fl);
        check("bpc8 carry", z, 32'h40000000);
        for (int i = 0; i < 8; i++) begin
            ra = {1'($urandom), 8'($urandom_range(150, 100)),
                  23'($urandom)};
            rb = {1'($urandom), 8'($urandom_range(150, 100)),
                  23'($urandom)};
            run(1'b1, ra, rb, z, lat, nb, fl);
            check($sformatf("bpc8 rnd %h*%h", ra, rb), z, ref_mul(ra, rb));
            check($sformatf("bpc8 rnd lat %0d", i), 32'(lat), 32'd12);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
